// File: rtl/shared_reg_write_arbiter_pkg.sv
// Shared types, defaults and helpers for the round-robin shared-register write arbiter.
package shared_reg_write_arbiter_pkg;

    localparam int DEF_N  = 4;
    localparam int DEF_W  = 8;
    localparam int DEF_CW = 8;
    localparam int MAX_N  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // Index to one-hot over the widest supported requester count; callers slice to N.
    function automatic logic [MAX_N-1:0] onehot(input logic [2:0] idx);
        return MAX_N'(1) << idx;
    endfunction

endpackage

// File: rtl/shared_reg_en.sv
// Enabled D-type storage register: loads d when en is high, otherwise holds.
module shared_reg_en #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/shared_reg_write_arbiter.sv
// Round-robin arbitration of N requesters onto one shared register; one write per two cycles.
module shared_reg_write_arbiter
    import shared_reg_write_arbiter_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  wdata,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    ack,
    output logic [W-1:0]    q,
    output logic            busy,
    output logic [CW-1:0]   wr_count
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t          state, nstate;
    logic [IW-1:0]   sel, rr_ptr, winner;
    logic [MAX_N-1:0] win_oh;
    logic            any_req;
    logic            en;
    logic [W-1:0]    d;

    assign any_req = |req;

    // First set request at or after rr_ptr, wrapping modulo N.
    always_comb begin
        logic          found;
        logic [IW:0]   pos;
        winner = '0;
        found  = 1'b0;
        pos    = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, rr_ptr} + (IW+1)'(i);
            if (pos >= (IW+1)'(N))
                pos = pos - (IW+1)'(N);
            if (!found && req[pos[IW-1:0]]) begin
                winner = pos[IW-1:0];
                found  = 1'b1;
            end
        end
    end

    assign win_oh = onehot(3'(winner));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (any_req) nstate = WRITE;
            WRITE:   nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel      <= '0;
            gnt      <= '0;
            rr_ptr   <= '0;
            wr_count <= '0;
        end else if (state == IDLE) begin
            if (any_req) begin
                sel <= winner;
                gnt <= win_oh[N-1:0];
            end
        end else begin
            gnt      <= '0;
            wr_count <= wr_count + 1'b1;
            rr_ptr   <= (sel == IW'(N-1)) ? '0 : sel + 1'b1;
        end
    end

    assign busy = (state == WRITE);
    assign ack  = busy ? gnt : '0;
    assign en   = busy;
    assign d    = wdata[int'(sel)*W +: W];

    shared_reg_en #(.W(W)) u_reg (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (d),
        .q     (q)
    );

endmodule

// File: tb/tb_shared_reg_write_arbiter.sv
// Randomized and directed checks of the shared register arbiter against a transaction-level model.
module tb_shared_reg_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]   gnt, ack;
    logic [W-1:0]   q;
    logic           busy;
    logic [CW-1:0]  wr_count;

    shared_reg_write_arbiter #(.N(N), .W(W), .CW(CW)) dut (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata),
        .gnt(gnt), .ack(ack), .q(q), .busy(busy), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level model: register value, completed writes, round-robin start point.
    logic [W-1:0] m_q;
    int           m_cnt;
    int           m_ptr;

    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        for (int i = 0; i < N; i++)
            if (r[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [N*W-1:0] rand_wdata();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    task automatic model_reset();
        m_q = '0; m_cnt = 0; m_ptr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req = '0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Drives one arbitrated write from an IDLE negedge; returns the winner. Ends on a negedge.
    task automatic txn(input logic [N-1:0] r, input logic [N*W-1:0] wd,
                       input logic [N-1:0] r_mid, input logic [N*W-1:0] wd_mid, output int w);
        w = rr_pick(r, m_ptr);
        req = r; wdata = wd;
        @(posedge clk); #1;
        n_cmp++;
        if (gnt !== oh(w) || ack !== oh(w) || busy !== 1'b1) begin
            n_err++;
            $display("FAIL txn_grant: gnt=%b ack=%b busy=%b, expected gnt=ack=%b busy=1", gnt, ack, busy, oh(w));
        end
        @(negedge clk);
        req = r_mid; wdata = wd_mid;
        @(posedge clk); #1;
        m_q   = wd_mid[w*W +: W];
        m_cnt = (m_cnt + 1) % (1 << CW);
        m_ptr = (w + 1) % N;
        n_cmp++;
        if (q !== m_q || wr_count !== CW'(m_cnt) || gnt !== '0 || ack !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL txn_close: q=%h cnt=%0d gnt=%b ack=%b busy=%b, expected q=%h cnt=%0d gnt=0 ack=0 busy=0",
                     q, wr_count, gnt, ack, busy, m_q, m_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int w;
        logic [N*W-1:0] wd;
        #1;
        n_cmp++;
        if (q !== '0 || gnt !== '0 || ack !== '0 || busy !== 1'b0 || wr_count !== '0) begin
            n_err++;
            $display("FAIL reset_initial: q=%h gnt=%b ack=%b busy=%b cnt=%0d, expected all 0", q, gnt, ack, busy, wr_count);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        model_reset();
        wd = '0; wd[0 +: W] = 8'h5A;
        txn(4'b0001, wd, 4'b0000, wd, w);
        // Second write in flight when reset hits mid-cycle.
        wd[1*W +: W] = 8'h77;
        req = 4'b0010; wdata = wd;
        @(posedge clk); #1;
        n_cmp++;
        if (q !== 8'h5A || busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre: q=%h busy=%b, expected q=5a busy=1", q, busy);
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (q !== '0 || gnt !== '0 || ack !== '0 || busy !== 1'b0 || wr_count !== '0) begin
            n_err++;
            $display("FAIL reset_async: q=%h gnt=%b ack=%b busy=%b cnt=%0d, expected all 0", q, gnt, ack, busy, wr_count);
        end
        @(negedge clk);
        reset = 1'b0; req = '0;
        model_reset();
    endtask

    task automatic test_single();
        int w;
        logic [N*W-1:0] wd;
        wd = rand_wdata();
        wd[2*W +: W] = 8'hA5;
        txn(4'b0100, wd, 4'b0000, wd, w);
        @(posedge clk); #1;
        n_cmp++;
        if (ack !== '0 || gnt !== '0 || q !== 8'hA5 || wr_count !== CW'(1)) begin
            n_err++;
            $display("FAIL single_hold: ack=%b gnt=%b q=%h cnt=%0d, expected ack=0 gnt=0 q=a5 cnt=1", ack, gnt, q, wr_count);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        int w, wnext;
        logic [N-1:0] cur;
        logic [N*W-1:0] wd;
        do_reset();
        wd  = {8'h13, 8'h12, 8'h11, 8'h10};
        cur = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wnext = rr_pick(cur, m_ptr);
            txn(cur, wd, cur & ~oh(wnext), wd, w);
            n_cmp++;
            if (q !== 8'h10 + W'(k % N)) begin
                n_err++;
                $display("FAIL contention_q%0d: q=%h, expected %h", k, q, 8'h10 + W'(k % N));
            end
        end
        n_cmp++;
        if (wr_count !== CW'(5)) begin
            n_err++;
            $display("FAIL contention_count: cnt=%0d, expected 5", wr_count);
        end
    endtask

    task automatic test_fairness();
        int w;
        logic [N*W-1:0] wd;
        // Pointer now sits at 1 after the contention round.
        wd = rand_wdata();
        txn(4'b1001, wd, 4'b0001, wd, w);
        n_cmp++;
        if (q !== wd[3*W +: W]) begin
            n_err++;
            $display("FAIL fair_ptr1: q=%h, expected port3 data %h", q, wd[3*W +: W]);
        end
        wd = rand_wdata();
        txn(4'b0100, wd, 4'b0000, wd, w);
        wd = rand_wdata();
        txn(4'b1001, wd, 4'b0001, wd, w);
        n_cmp++;
        if (q !== wd[3*W +: W]) begin
            n_err++;
            $display("FAIL fair_ptr3_first: q=%h, expected port3 data %h", q, wd[3*W +: W]);
        end
        wd = rand_wdata();
        txn(4'b0001, wd, 4'b0000, wd, w);
        n_cmp++;
        if (q !== wd[0 +: W]) begin
            n_err++;
            $display("FAIL fair_ptr3_second: q=%h, expected port0 data %h", q, wd[0 +: W]);
        end
    endtask

    task automatic test_abort();
        int w;
        logic [N*W-1:0] wd;
        do_reset();
        wd = rand_wdata();
        wd[1*W +: W] = 8'hFF;
        req = 4'b0010; wdata = wd;
        @(posedge clk); #1;
        n_cmp++;
        if (gnt !== 4'b0010 || ack !== 4'b0010) begin
            n_err++;
            $display("FAIL abort_grant: gnt=%b ack=%b, expected 0010", gnt, ack);
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (ack !== '0 || q !== '0 || wr_count !== '0) begin
            n_err++;
            $display("FAIL abort_reset: ack=%b q=%h cnt=%0d, expected 0", ack, q, wr_count);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        txn(4'b0010, wd, 4'b0010, wd, w);
        n_cmp++;
        if (q !== 8'hFF || w != 1) begin
            n_err++;
            $display("FAIL abort_regrant: q=%h, expected ff", q);
        end
        req = '0;
    endtask

    task automatic test_drop_and_wrap();
        int w;
        logic [N*W-1:0] wd, wd2;
        do_reset();
        wd = rand_wdata(); wd2 = rand_wdata();
        txn(4'b0001, wd, 4'b0000, wd2, w);
        n_cmp++;
        if (q !== wd2[0 +: W]) begin
            n_err++;
            $display("FAIL drop_load: q=%h, expected %h", q, wd2[0 +: W]);
        end
        while (m_cnt != (1 << CW) - 1) begin
            if ($urandom_range(0, 3) == 0) begin
                req = '0; wdata = rand_wdata();
                @(posedge clk); #1;
                n_cmp++;
                if (q !== m_q || busy !== 1'b0 || gnt !== '0) begin
                    n_err++;
                    $display("FAIL idle_hold: q=%h busy=%b gnt=%b, expected q=%h busy=0 gnt=0", q, busy, gnt, m_q);
                end
                @(negedge clk);
            end
            txn(N'($urandom_range(1, (1 << N) - 1)), rand_wdata(),
                N'($urandom_range(0, (1 << N) - 1)), rand_wdata(), w);
        end
        n_cmp++;
        if (wr_count !== CW'((1 << CW) - 1)) begin
            n_err++;
            $display("FAIL wrap_pre: cnt=%0d, expected %0d", wr_count, (1 << CW) - 1);
        end
        txn(4'b1000, rand_wdata(), 4'b0000, rand_wdata(), w);
        n_cmp++;
        if (wr_count !== '0) begin
            n_err++;
            $display("FAIL wrap: cnt=%0d, expected 0", wr_count);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_abort();
        test_drop_and_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
